// File: rtl/wt_fifo_burst_writer_pkg.sv
// ---------------------------------------------------------------------------
// wt_fifo_burst_writer_pkg
// Shared constants and types for the turbine-result FIFO burst writer.
//   N_WindTurbine  : number of wind turbines in the system (words per burst)
//   DATA_W_DEFAULT : width of one turbine result word
//   writerState_e  : burst writer FSM states
// ---------------------------------------------------------------------------
package wt_fifo_burst_writer_pkg;

  localparam int N_WindTurbine  = 6;
  localparam int DATA_W_DEFAULT = 32;

  // IDLE waits for start, RUN issues bank reads and moves words toward the
  // FIFO, FLUSH presents the final word, DONE emits the completion pulse.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } writerState_e;

endpackage

// File: rtl/wt_fifo_burst_writer_skid_reg.sv
// ---------------------------------------------------------------------------
// wt_fifo_burst_writer_skid_reg
// One-entry holding register that parks a bank word which came back while the
// FIFO was full (or while an older word was still parked).
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   clear_i  : synchronous clear, wins over load/unload
//   load_i   : capture data_i and mark the entry valid
//   unload_i : release the entry (data_o is consumed this cycle)
//   data_i   : word to park
//   data_o   : parked word
//   valid_o  : entry holds a word
// ---------------------------------------------------------------------------
module wt_fifo_burst_writer_skid_reg
  import wt_fifo_burst_writer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              unload_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  // A load takes precedence over an unload so a word arriving in the same
  // cycle the old one leaves is never dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/wt_fifo_burst_writer.sv
// ---------------------------------------------------------------------------
// wt_fifo_burst_writer
// Producer end of the per-turbine system FIFO path. A start pulse reads N_WT
// results from a synchronous result bank (1-cycle read latency) and pushes
// them, in turbine order, as one write burst into the system FIFO. FIFO full
// back-pressure is absorbed by a one-entry skid register.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   rst_user  : synchronous user clear, active-high, wins over start
//   start     : 1-cycle pulse that begins a burst
//   rd_en     : result-bank read strobe
//   rd_addr   : result-bank address (turbine index)
//   rd_data   : bank data, valid the cycle after rd_en
//   fifo_full : FIFO full flag
//   wr_en     : registered FIFO write request
//   wr_data   : registered FIFO write data
//   busy      : burst in progress
//   done      : 1-cycle pulse after the last word is written
//   overrun   : sticky, start seen while a burst was active
// ---------------------------------------------------------------------------
module wt_fifo_burst_writer
  import wt_fifo_burst_writer_pkg::*;
#(
  parameter int N_WT   = N_WindTurbine,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rst_user,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  // One extra bit lets the issue counter sit at N_WT once every read is out.
  localparam logic [ADDR_W:0] ISSUE_LAST = (ADDR_W + 1)'(N_WT);

  writerState_e      state_q, state_d;
  logic [ADDR_W:0]   issueCnt_q, issueCnt_d;
  logic              rdPend_q;
  logic              wrEn_q, wrEn_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;
  logic              overrun_q, overrun_d;

  logic              rdIssue;
  logic              skidValid;
  logic [DATA_W-1:0] skidData;
  logic              skidLoad;
  logic              skidUnload;
  logic              skidValidNext;

  // Parked word from a back-pressured bank return.
  wt_fifo_burst_writer_skid_reg #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clear_i  (rst_user),
    .load_i   (skidLoad),
    .unload_i (skidUnload),
    .data_i   (rd_data),
    .data_o   (skidData),
    .valid_o  (skidValid)
  );

  // Datapath steering. A read is only issued when its returning word is sure
  // to have somewhere to go: FIFO not full and the skid empty. The returning
  // word goes straight to the write register when it can, otherwise it is
  // parked. A parked word always leaves before any newer word, which keeps
  // turbine order intact.
  always_comb begin
    rdIssue    = 1'b0;
    skidUnload = 1'b0;
    skidLoad   = 1'b0;
    wrEn_d     = 1'b0;
    wrData_d   = wrData_q;

    if ((state_q == ST_RUN) && (issueCnt_q < ISSUE_LAST) && !fifo_full && !skidValid) begin
      rdIssue = 1'b1;
    end

    if (skidValid && !fifo_full) begin
      skidUnload = 1'b1;
      wrEn_d     = 1'b1;
      wrData_d   = skidData;
    end else if (rdPend_q && !fifo_full) begin
      wrEn_d   = 1'b1;
      wrData_d = rd_data;
    end

    if (rdPend_q && (fifo_full || skidValid)) begin
      skidLoad = 1'b1;
    end

    skidValidNext = skidLoad || (skidValid && !skidUnload);
  end

  // Next-state logic. RUN ends once every read is issued and no word will be
  // sitting in the skid after this edge; at that point the final word is
  // being loaded into the write register, so FLUSH is exactly the cycle it is
  // presented and DONE follows immediately.
  always_comb begin
    state_d    = state_q;
    issueCnt_d = issueCnt_q;
    overrun_d  = overrun_q;

    if (start && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          issueCnt_d = '0;
        end
      end
      ST_RUN: begin
        if (rdIssue) begin
          issueCnt_d = issueCnt_q + 1'b1;
        end
        if ((issueCnt_q == ISSUE_LAST) && !skidValidNext) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        issueCnt_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rst_user) begin
      state_d    = ST_IDLE;
      issueCnt_d = '0;
      overrun_d  = 1'b0;
    end
  end

  // State, counters and the registered FIFO interface. The user clear drops
  // any in-flight bank read and any pending write request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      issueCnt_q <= '0;
      rdPend_q   <= 1'b0;
      wrEn_q     <= 1'b0;
      wrData_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      issueCnt_q <= issueCnt_d;
      rdPend_q   <= rdIssue && !rst_user;
      wrEn_q     <= wrEn_d && !rst_user;
      wrData_q   <= wrData_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rd_en   = rdIssue;
  assign rd_addr = issueCnt_q[ADDR_W-1:0];
  assign wr_en   = wrEn_q;
  assign wr_data = wrData_q;
  assign busy    = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done    = (state_q == ST_DONE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_wt_fifo_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_wt_fifo_burst_writer
// Self-checking bench for the turbine-result FIFO burst writer. A 4-turbine
// instance covers bursts, back-pressure, overrun and both resets; a separate
// 1-turbine instance covers the single-word burst.
// ---------------------------------------------------------------------------
module tb_wt_fifo_burst_writer;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rstUser, start, fifoFull;
  logic          rdEn, wrEn, busy, done, overrun;
  logic [AW-1:0] rdAddr;
  logic [DW-1:0] rdData, wrData;

  logic          rstUser1, start1, fifoFull1;
  logic          rdEn1, wrEn1, busy1, done1, overrun1;
  logic [AW-1:0] rdAddr1;
  logic [DW-1:0] rdData1, wrData1;

  logic [DW-1:0] bank  [0:15];
  logic [DW-1:0] bank1 [0:15];

  // Per-cycle trace of one burst on the 4-turbine instance.
  logic          fullPat    [0:63];
  logic          rdEnLog    [0:63];
  logic [AW-1:0] rdAddrLog  [0:63];
  logic          wrEnLog    [0:63];
  logic [DW-1:0] wrDataLog  [0:63];
  logic          doneLog    [0:63];
  logic          busyLog    [0:63];
  logic          overrunLog [0:63];

  int checkCount = 0;
  int passCount  = 0;

  wt_fifo_burst_writer #(.N_WT(NW), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rst_user  (rstUser),
    .start     (start),
    .rd_en     (rdEn),
    .rd_addr   (rdAddr),
    .rd_data   (rdData),
    .fifo_full (fifoFull),
    .wr_en     (wrEn),
    .wr_data   (wrData),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  wt_fifo_burst_writer #(.N_WT(1), .DATA_W(DW), .ADDR_W(AW)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .rst_user  (rstUser1),
    .start     (start1),
    .rd_en     (rdEn1),
    .rd_addr   (rdAddr1),
    .rd_data   (rdData1),
    .fifo_full (fifoFull1),
    .wr_en     (wrEn1),
    .wr_data   (wrData1),
    .busy      (busy1),
    .done      (done1),
    .overrun   (overrun1)
  );

  // Synchronous result banks with one cycle of read latency.
  always @(posedge clk) begin
    if (rdEn)  rdData  <= bank[rdAddr];
    if (rdEn1) rdData1 <= bank1[rdAddr1];
  end

  // Runs one burst: start in cycle 0, optional extra start / user clear in a
  // given cycle, fifo_full from fullPat, outputs logged 3 ns into each cycle.
  task automatic runBurst(input int cycles, input int extraStart, input int userRst);
    start    = 1'b1;
    rstUser  = (userRst == 0);
    fifoFull = fullPat[0];
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk); #1;
      start    = (k == extraStart);
      rstUser  = (k == userRst);
      fifoFull = fullPat[k];
      #2;
      rdEnLog[k]    = rdEn;
      rdAddrLog[k]  = rdAddr;
      wrEnLog[k]    = wrEn;
      wrDataLog[k]  = wrData;
      doneLog[k]    = done;
      busyLog[k]    = busy;
      overrunLog[k] = overrun;
    end
    start    = 1'b0;
    rstUser  = 1'b0;
    fifoFull = 1'b0;
  endtask

  task automatic clearFull();
    for (int i = 0; i < 64; i++) fullPat[i] = 1'b0;
  endtask

  task automatic loadBank(input bit fixed);
    for (int i = 0; i < NW; i++) begin
      bank[i] = fixed ? DW'(32'h11 * (i + 1)) : $urandom();
    end
  endtask

  task automatic test_reset();
    logic [DW+AW+5:0] outs;
    logic [DW+3:0]    outs1;
    rst = 1'b0; rstUser = 1'b0; start = 1'b0; fifoFull = 1'b0;
    rstUser1 = 1'b0; start1 = 1'b0; fifoFull1 = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    outs  = {rdEn, rdAddr, wrEn, wrData, busy, done, overrun};
    outs1 = {rdEn1, wrEn1, wrData1, busy1, done1};
    checkCount++;
    if (outs !== '0) $display("FAIL reset.outputs got=%h exp=0", outs);
    else passCount++;
    checkCount++;
    if (outs1 !== '0) $display("FAIL reset.outputs1 got=%h exp=0", outs1);
    else passCount++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_burst();
    for (int it = 0; it < 3; it++) begin
      loadBank(it == 0);
      clearFull();
      runBurst(10, -1, -1);
      for (int k = 1; k <= 10; k++) begin
        logic expRd, expWr, expDone, expBusy;
        expRd   = (k >= 1) && (k <= NW);
        expWr   = (k >= 3) && (k <= NW + 2);
        expDone = (k == NW + 3);
        expBusy = (k >= 1) && (k <= NW + 2);
        checkCount++;
        if (rdEnLog[k] !== expRd) $display("FAIL basic.rdEn cyc=%0d got=%b exp=%b", k, rdEnLog[k], expRd);
        else passCount++;
        if (expRd) begin
          checkCount++;
          if (rdAddrLog[k] !== AW'(k - 1)) $display("FAIL basic.rdAddr cyc=%0d got=%0d exp=%0d", k, rdAddrLog[k], k - 1);
          else passCount++;
        end
        checkCount++;
        if (wrEnLog[k] !== expWr) $display("FAIL basic.wrEn cyc=%0d got=%b exp=%b", k, wrEnLog[k], expWr);
        else passCount++;
        if (expWr) begin
          checkCount++;
          if (wrDataLog[k] !== bank[k - 3]) $display("FAIL basic.wrData cyc=%0d got=%h exp=%h", k, wrDataLog[k], bank[k - 3]);
          else passCount++;
        end
        checkCount++;
        if (doneLog[k] !== expDone) $display("FAIL basic.done cyc=%0d got=%b exp=%b", k, doneLog[k], expDone);
        else passCount++;
        checkCount++;
        if (busyLog[k] !== expBusy) $display("FAIL basic.busy cyc=%0d got=%b exp=%b", k, busyLog[k], expBusy);
        else passCount++;
      end
    end
  endtask

  // Back-pressure: the model only cares about what the FIFO receives, that no
  // read is issued while full, and that done follows the last write.
  task automatic test_backpressure();
    for (int it = 0; it < 6; it++) begin
      logic [DW-1:0] words[$];
      int nextAddr, lastWr, nDone, doneAt;
      loadBank(it == 0);
      clearFull();
      for (int k = 0; k <= 40; k++) begin
        if (it == 0) fullPat[k] = (k >= 3) && (k <= 5);
        else         fullPat[k] = (k <= 25) && ($urandom_range(0, 2) == 0);
      end
      runBurst(40, -1, -1);
      nextAddr = 0; lastWr = -1; nDone = 0; doneAt = -1;
      for (int k = 1; k <= 40; k++) begin
        if (rdEnLog[k]) begin
          checkCount++;
          if (fullPat[k] !== 1'b0) $display("FAIL bp.rdWhileFull it=%0d cyc=%0d got=rd_en exp=stall", it, k);
          else passCount++;
          checkCount++;
          if (rdAddrLog[k] !== AW'(nextAddr)) $display("FAIL bp.rdAddr it=%0d cyc=%0d got=%0d exp=%0d", it, k, rdAddrLog[k], nextAddr);
          else passCount++;
          nextAddr++;
        end
        if (wrEnLog[k]) begin
          words.push_back(wrDataLog[k]);
          lastWr = k;
        end
        if (doneLog[k]) begin
          nDone++;
          doneAt = k;
        end
      end
      checkCount++;
      if (nextAddr != NW) $display("FAIL bp.reads it=%0d got=%0d exp=%0d", it, nextAddr, NW);
      else passCount++;
      checkCount++;
      if (words.size() != NW) $display("FAIL bp.writes it=%0d got=%0d exp=%0d", it, words.size(), NW);
      else passCount++;
      for (int i = 0; i < NW && i < words.size(); i++) begin
        checkCount++;
        if (words[i] !== bank[i]) $display("FAIL bp.order it=%0d idx=%0d got=%h exp=%h", it, i, words[i], bank[i]);
        else passCount++;
      end
      checkCount++;
      if (nDone != 1) $display("FAIL bp.doneCount it=%0d got=%0d exp=1", it, nDone);
      else passCount++;
      checkCount++;
      if (doneAt != lastWr + 1) $display("FAIL bp.doneCycle it=%0d got=%0d exp=%0d", it, doneAt, lastWr + 1);
      else passCount++;
      if (doneAt > 0) begin
        checkCount++;
        if (busyLog[doneAt] !== 1'b0) $display("FAIL bp.busyAtDone it=%0d got=%b exp=0", it, busyLog[doneAt]);
        else passCount++;
      end
      if (it == 0) begin
        checkCount++;
        if (wrEnLog[3] !== 1'b1 || wrDataLog[3] !== bank[0]) $display("FAIL bp.firstWrite got=%b/%h exp=1/%h", wrEnLog[3], wrDataLog[3], bank[0]);
        else passCount++;
      end
    end
  endtask

  task automatic test_overrun();
    loadBank(1'b0);
    clearFull();
    runBurst(12, 3, -1);
    for (int k = 1; k <= 12; k++) begin
      logic expOv, expWr;
      expOv = (k >= 4);
      expWr = (k >= 3) && (k <= NW + 2);
      checkCount++;
      if (overrunLog[k] !== expOv) $display("FAIL ovr.overrun cyc=%0d got=%b exp=%b", k, overrunLog[k], expOv);
      else passCount++;
      checkCount++;
      if (wrEnLog[k] !== expWr) $display("FAIL ovr.wrEn cyc=%0d got=%b exp=%b", k, wrEnLog[k], expWr);
      else passCount++;
      if (expWr) begin
        checkCount++;
        if (wrDataLog[k] !== bank[k - 3]) $display("FAIL ovr.wrData cyc=%0d got=%h exp=%h", k, wrDataLog[k], bank[k - 3]);
        else passCount++;
      end
      checkCount++;
      if (doneLog[k] !== (k == NW + 3)) $display("FAIL ovr.done cyc=%0d got=%b exp=%b", k, doneLog[k], (k == NW + 3));
      else passCount++;
    end
    @(posedge clk); #1; rstUser = 1'b1;
    @(posedge clk); #1; rstUser = 1'b0;
    #2;
    checkCount++;
    if (overrun !== 1'b0) $display("FAIL ovr.clear got=%b exp=0", overrun);
    else passCount++;
  endtask

  task automatic test_user_clear();
    loadBank(1'b0);
    clearFull();
    runBurst(12, -1, 4);
    checkCount++;
    if (wrEnLog[3] !== 1'b1 || wrDataLog[3] !== bank[0]) $display("FAIL uclr.preWrite got=%b/%h exp=1/%h", wrEnLog[3], wrDataLog[3], bank[0]);
    else passCount++;
    for (int k = 5; k <= 12; k++) begin
      checkCount++;
      if ({busyLog[k], wrEnLog[k], rdEnLog[k], doneLog[k]} !== 4'b0000)
        $display("FAIL uclr.quiet cyc=%0d got=%b exp=0000", k, {busyLog[k], wrEnLog[k], rdEnLog[k], doneLog[k]});
      else passCount++;
    end
    loadBank(1'b0);
    runBurst(10, -1, -1);
    for (int k = 1; k <= 10; k++) begin
      logic expWr;
      expWr = (k >= 3) && (k <= NW + 2);
      if (k <= NW) begin
        checkCount++;
        if (rdEnLog[k] !== 1'b1 || rdAddrLog[k] !== AW'(k - 1)) $display("FAIL uclr.reread cyc=%0d got=%b/%0d exp=1/%0d", k, rdEnLog[k], rdAddrLog[k], k - 1);
        else passCount++;
      end
      checkCount++;
      if (wrEnLog[k] !== expWr || (expWr && wrDataLog[k] !== bank[k - 3]))
        $display("FAIL uclr.rewrite cyc=%0d got=%b/%h exp=%b", k, wrEnLog[k], wrDataLog[k], expWr);
      else passCount++;
    end
  endtask

  task automatic test_async_reset();
    logic [DW+AW+5:0] outs;
    loadBank(1'b0);
    clearFull();
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #3 rst = 1'b0;
    #1;
    outs = {rdEn, rdAddr, wrEn, wrData, busy, done, overrun};
    checkCount++;
    if (outs !== '0) $display("FAIL arst.outputs got=%h exp=0", outs);
    else passCount++;
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    runBurst(10, -1, -1);
    for (int k = 1; k <= 10; k++) begin
      logic expWr;
      expWr = (k >= 3) && (k <= NW + 2);
      checkCount++;
      if (wrEnLog[k] !== expWr || (expWr && wrDataLog[k] !== bank[k - 3]))
        $display("FAIL arst.write cyc=%0d got=%b/%h exp=%b", k, wrEnLog[k], wrDataLog[k], expWr);
      else passCount++;
      checkCount++;
      if (doneLog[k] !== (k == NW + 3)) $display("FAIL arst.done cyc=%0d got=%b exp=%b", k, doneLog[k], (k == NW + 3));
      else passCount++;
    end
  endtask

  task automatic test_single_turbine();
    for (int it = 0; it < 2; it++) begin
      logic [DW-1:0] word;
      word = (it == 0) ? 32'hDEADBEEF : $urandom();
      bank1[0] = word;
      start1 = 1'b1;
      for (int k = 1; k <= 7; k++) begin
        @(posedge clk); #1;
        start1 = 1'b0;
        #2;
        checkCount++;
        if (rdEn1 !== (k == 1) || (k == 1 && rdAddr1 !== '0)) $display("FAIL one.rd cyc=%0d got=%b/%0d exp=%b/0", k, rdEn1, rdAddr1, (k == 1));
        else passCount++;
        checkCount++;
        if (wrEn1 !== (k == 3) || (k == 3 && wrData1 !== word)) $display("FAIL one.wr cyc=%0d got=%b/%h exp=%b/%h", k, wrEn1, wrData1, (k == 3), word);
        else passCount++;
        checkCount++;
        if (done1 !== (k == 4)) $display("FAIL one.done cyc=%0d got=%b exp=%b", k, done1, (k == 4));
        else passCount++;
        checkCount++;
        if (busy1 !== (k <= 3)) $display("FAIL one.busy cyc=%0d got=%b exp=%b", k, busy1, (k <= 3));
        else passCount++;
      end
    end
  endtask

  // Hard stop in case the sequence ever wedges.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting wt_fifo_burst_writer bench");
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_overrun();
    test_user_clear();
    test_async_reset();
    test_single_turbine();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
